// File: rtl/rv32i_if_stage_if.sv
// Fetch-stage bus: pipeline control, instruction-memory port and IF/ID register outputs.
// The slave modport is the fetch stage itself; the master is the surrounding pipeline/memory.
interface rv32i_if_stage_if #(
    parameter int WIDTH = 32
);
    logic             i_stall;
    logic             i_redirect;
    logic [WIDTH-1:0] i_target;
    logic [WIDTH-1:0] i_inst;
    logic [WIDTH-1:0] o_inst_addr;
    logic [WIDTH-1:0] o_if_pc;
    logic [WIDTH-1:0] o_if_pc4;
    logic [WIDTH-1:0] o_if_inst;
    logic             o_if_valid;
    logic             o_misalign;

    modport master (
        output i_stall, i_redirect, i_target, i_inst,
        input  o_inst_addr, o_if_pc, o_if_pc4, o_if_inst, o_if_valid, o_misalign
    );

    modport slave (
        input  i_stall, i_redirect, i_target, i_inst,
        output o_inst_addr, o_if_pc, o_if_pc4, o_if_inst, o_if_valid, o_misalign
    );
endinterface

// File: rtl/rv32i_if_stage.sv
// RV32I instruction-fetch stage: PC register plus IF/ID pipeline register with stall and redirect.
// Optional RV32I_IF_MISALIGN_CHK_EN adds a one-cycle misaligned-redirect flag.
module rv32i_if_stage #(
    parameter int               WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = '0,
    parameter logic [WIDTH-1:0] NOP_INST = WIDTH'(32'h0000_0013)
) (
    input  logic clk,
    input  logic rst,
    rv32i_if_stage_if.slave bus
);
    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] pc_reg, pc_next;
    logic [WIDTH-1:0] if_pc_reg, if_pc_next;
    logic [WIDTH-1:0] if_pc4_reg, if_pc4_next;
    logic [WIDTH-1:0] if_inst_reg, if_inst_next;
    logic             if_valid_reg, if_valid_next;
    logic [WIDTH-1:0] pc_plus4;
    logic [WIDTH-1:0] target_aligned;

    // Wraps naturally modulo 2^WIDTH.
    assign pc_plus4       = pc_reg + WIDTH'(4);
    assign target_aligned = bus.i_target & ~WIDTH'(3);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= ST_RUN;
            pc_reg       <= RESET_PC;
            if_pc_reg    <= '0;
            if_pc4_reg   <= '0;
            if_inst_reg  <= NOP_INST;
            if_valid_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            pc_reg       <= pc_next;
            if_pc_reg    <= if_pc_next;
            if_pc4_reg   <= if_pc4_next;
            if_inst_reg  <= if_inst_next;
            if_valid_reg <= if_valid_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        pc_next       = pc_reg;
        if_pc_next    = if_pc_reg;
        if_pc4_next   = if_pc4_reg;
        if_inst_next  = if_inst_reg;
        if_valid_next = if_valid_reg;
        if (bus.i_redirect) begin
            // Redirect overrides any stall; the word fetched this cycle is squashed.
            state_next    = ST_RUN;
            pc_next       = target_aligned;
            if_pc_next    = pc_reg;
            if_pc4_next   = pc_plus4;
            if_inst_next  = NOP_INST;
            if_valid_next = 1'b0;
        end else if (bus.i_stall) begin
            state_next = ST_HOLD;
        end else begin
            state_next    = ST_RUN;
            pc_next       = pc_plus4;
            if_pc_next    = pc_reg;
            if_pc4_next   = pc_plus4;
            if_inst_next  = bus.i_inst;
            if_valid_next = 1'b1;
        end
    end

    assign bus.o_inst_addr = pc_reg;
    assign bus.o_if_pc     = if_pc_reg;
    assign bus.o_if_pc4    = if_pc4_reg;
    assign bus.o_if_inst   = if_inst_reg;
    assign bus.o_if_valid  = if_valid_reg;

`ifdef RV32I_IF_MISALIGN_CHK_EN
    logic misalign_reg, misalign_next;

    always_comb begin
        misalign_next = bus.i_redirect & (|bus.i_target[1:0]);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            misalign_reg <= 1'b0;
        end else begin
            misalign_reg <= misalign_next;
        end
    end

    assign bus.o_misalign = misalign_reg;
`else
    assign bus.o_misalign = 1'b0;
`endif

endmodule

// File: tb/tb_rv32i_if_stage.sv
// Directed bench for rv32i_if_stage: advance, stall, redirect, redirect-under-stall,
// back-to-back redirects, misaligned target, PC wrap and asynchronous mid-run reset.
module tb_rv32i_if_stage;
    localparam logic [31:0] NOP  = 32'h0000_0013;
    localparam logic [31:0] WPC  = 32'hFFFF_FFF8;

    logic clk;
    logic rst;
    int   vec_count;
    int   err_count;

`ifdef RV32I_IF_MISALIGN_CHK_EN
    localparam logic [31:0] MIS_EXP = 32'd1;
`else
    localparam logic [31:0] MIS_EXP = 32'd0;
`endif

    rv32i_if_stage_if #(.WIDTH(32)) bus0 ();
    rv32i_if_stage_if #(.WIDTH(32)) bus1 ();

    rv32i_if_stage #(.WIDTH(32), .RESET_PC(32'h0), .NOP_INST(NOP)) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0.slave)
    );

    rv32i_if_stage #(.WIDTH(32), .RESET_PC(WPC), .NOP_INST(NOP)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1.slave)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {8'hA5, a[23:0]};
    endfunction

    // Combinational instruction memory model.
    assign bus0.i_inst = mem_word(bus0.o_inst_addr);
    assign bus1.i_inst = mem_word(bus1.o_inst_addr);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        vec_count++;
        if (obs !== exp_v) begin
            err_count++;
            $display("FAIL %s: got %08h expected %08h", tag, obs, exp_v);
        end else begin
            $display("ok   %s: %08h", tag, obs);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_ifid(input string tag, input logic [31:0] addr, input logic [31:0] pc,
                              input logic [31:0] inst, input logic [31:0] valid);
        check({tag, ".addr"},  bus0.o_inst_addr, addr);
        check({tag, ".pc"},    bus0.o_if_pc, pc);
        check({tag, ".pc4"},   bus0.o_if_pc4, pc + 32'd4);
        check({tag, ".inst"},  bus0.o_if_inst, inst);
        check({tag, ".valid"}, {31'd0, bus0.o_if_valid}, valid);
    endtask

    initial begin
        vec_count = 0;
        err_count = 0;
        rst = 1'b1;
        bus0.i_stall = 1'b0; bus0.i_redirect = 1'b0; bus0.i_target = '0;
        bus1.i_stall = 1'b0; bus1.i_redirect = 1'b0; bus1.i_target = '0;

        step();
        step();
        check("rst.addr", bus0.o_inst_addr, 32'h0);
        check("rst.pc", bus0.o_if_pc, 32'h0);
        check("rst.pc4", bus0.o_if_pc4, 32'h0);
        check("rst.inst", bus0.o_if_inst, NOP);
        check("rst.valid", {31'd0, bus0.o_if_valid}, 32'd0);
        check("rst.mis", {31'd0, bus0.o_misalign}, 32'd0);
        check("wrap.rst.addr", bus1.o_inst_addr, WPC);

        rst = 1'b0;
        // Advance: after edge k, pc = 4k and IF/ID holds pc 4(k-1).
        for (int k = 1; k <= 4; k++) begin
            step();
            check_ifid($sformatf("adv%0d", k), 32'(4 * k), 32'(4 * (k - 1)),
                       mem_word(32'(4 * (k - 1))), 32'd1);
            if (k == 1) check("wrap.e1.addr", bus1.o_inst_addr, 32'hFFFF_FFFC);
            if (k == 2) begin
                check("wrap.e2.addr", bus1.o_inst_addr, 32'h0);
                check("wrap.e2.pc",   bus1.o_if_pc, 32'hFFFF_FFFC);
                check("wrap.e2.pc4",  bus1.o_if_pc4, 32'h0);
            end
            if (k == 3) check("wrap.e3.addr", bus1.o_inst_addr, 32'h4);
        end

        // Stall at pc 0x10 for three edges.
        bus0.i_stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            check_ifid($sformatf("stall%0d", k), 32'h10, 32'h0C, mem_word(32'h0C), 32'd1);
        end
        bus0.i_stall = 1'b0;
        step();
        check_ifid("unstall0", 32'h14, 32'h10, mem_word(32'h10), 32'd1);
        step();
        check_ifid("unstall1", 32'h18, 32'h14, mem_word(32'h14), 32'd1);
        step();
        step();
        check("pre_redir.addr", bus0.o_inst_addr, 32'h20);

        // Redirect to 0x80 from pc 0x20.
        bus0.i_redirect = 1'b1;
        bus0.i_target   = 32'h80;
        step();
        check_ifid("redir", 32'h80, 32'h20, NOP, 32'd0);
        check("redir.mis", {31'd0, bus0.o_misalign}, 32'd0);
        bus0.i_redirect = 1'b0;
        step();
        check_ifid("redir+1", 32'h84, 32'h80, mem_word(32'h80), 32'd1);

        // Redirect together with stall: redirect wins.
        bus0.i_stall    = 1'b1;
        bus0.i_redirect = 1'b1;
        bus0.i_target   = 32'h40;
        step();
        check_ifid("rstall", 32'h40, 32'h84, NOP, 32'd0);
        bus0.i_stall    = 1'b0;
        bus0.i_redirect = 1'b0;
        step();
        check_ifid("rstall+1", 32'h44, 32'h40, mem_word(32'h40), 32'd1);

        // Back-to-back redirects: last one wins, bubble each cycle.
        bus0.i_redirect = 1'b1;
        bus0.i_target   = 32'h200;
        step();
        check_ifid("b2b0", 32'h200, 32'h44, NOP, 32'd0);
        bus0.i_target   = 32'h300;
        step();
        check_ifid("b2b1", 32'h300, 32'h200, NOP, 32'd0);
        bus0.i_redirect = 1'b0;
        step();
        check_ifid("b2b2", 32'h304, 32'h300, mem_word(32'h300), 32'd1);

        // Misaligned redirect target.
        bus0.i_redirect = 1'b1;
        bus0.i_target   = 32'h102;
        step();
        check("mis.addr", bus0.o_inst_addr, 32'h100);
        check("mis.flag", {31'd0, bus0.o_misalign}, MIS_EXP);
        bus0.i_redirect = 1'b0;
        step();
        check("mis+1.flag", {31'd0, bus0.o_misalign}, 32'd0);
        check_ifid("mis+1", 32'h104, 32'h100, mem_word(32'h100), 32'd1);
        check("wrap.mis", {31'd0, bus1.o_misalign}, 32'd0);

        // Asynchronous reset mid-cycle with redirect and stall pending.
        bus0.i_stall    = 1'b1;
        bus0.i_redirect = 1'b1;
        bus0.i_target   = 32'h503;
        #3;
        rst = 1'b1;
        #1;
        check("arst.addr", bus0.o_inst_addr, 32'h0);
        check("arst.pc", bus0.o_if_pc, 32'h0);
        check("arst.pc4", bus0.o_if_pc4, 32'h0);
        check("arst.inst", bus0.o_if_inst, NOP);
        check("arst.valid", {31'd0, bus0.o_if_valid}, 32'd0);
        check("arst.mis", {31'd0, bus0.o_misalign}, 32'd0);
        check("arst.wrap.addr", bus1.o_inst_addr, WPC);

        bus0.i_stall    = 1'b0;
        bus0.i_redirect = 1'b0;
        step();
        rst = 1'b0;
        step();
        check_ifid("post_rst", 32'h4, 32'h0, mem_word(32'h0), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
        $finish;
    end
endmodule

// File: doc/rv32i_if_stage.md
# rv32i_if_stage

Instruction-fetch stage of the RV32IM pipeline. Holds the program counter, drives the address input of the combinational instruction memory (`rv32i_inst_mem`), and registers the returned word into the IF/ID pipeline register. Also applies the hazard unit's stall and the EX-stage redirect (taken branch or jump), inserting a NOP bubble on redirect.

## Interface

Parameters:
- `WIDTH`, 32: address and instruction width.
- `RESET_PC`, 32'h0000_0000: PC value loaded on reset.
- `NOP_INST`, 32'h0000_0013: bubble instruction (`addi x0,x0,0`).

Ports:
- `clk`, input, 1: clock, rising-edge.
- `rst`, input, 1: reset, asynchronous, active-high.
- `i_stall`, input, 1: hazard-unit stall; holds the PC and IF/ID.
- `i_redirect`, input, 1: EX-stage taken branch or jump.
- `i_target`, input, WIDTH: redirect target address.
- `i_inst`, input, WIDTH: instruction word from the instruction memory `o_inst`.
- `o_inst_addr`, output, WIDTH: fetch address to the instruction memory `i_addr`; equals the PC register.
- `o_if_pc`, output, WIDTH: IF/ID, PC of the held instruction.
- `o_if_pc4`, output, WIDTH: IF/ID, `o_if_pc + 4`.
- `o_if_inst`, output, WIDTH: IF/ID, instruction word.
- `o_if_valid`, output, 1: IF/ID holds a real instruction (0 = bubble).
- `o_misalign`, output, 1: misaligned-redirect pulse (see Configuration).

## Operation

- PC register `pc`. `o_inst_addr = pc` directly from the flop, with no combinational path from any input.
- Update priority at each rising edge: `rst` > `i_redirect` > `i_stall` > advance.
- **Redirect** (`i_redirect=1`, regardless of `i_stall`):
  - `pc <= {i_target[WIDTH-1:2], 2'b00}`.
  - IF/ID loads a bubble: `o_if_inst=NOP_INST`, `o_if_valid=0`. `o_if_pc` and `o_if_pc4` load the current `pc` and `pc+4`.
- **Stall** (`i_stall=1`, `i_redirect=0`):
  - `pc` and all IF/ID outputs hold their values.
  - `o_inst_addr` stays stable, so the same word is re-fetched.
- **Advance** (neither asserted):
  - `pc <= pc + 4`, computed modulo 2^WIDTH; `32'hFFFF_FFFC` wraps to 0.
  - IF/ID loads `{pc, pc+4, i_inst, valid=1}`.
- Reset values:
  - `pc = RESET_PC`
  - `o_if_pc = 0`
  - `o_if_pc4 = 0`
  - `o_if_inst = NOP_INST`
  - `o_if_valid = 0`
  - `o_misalign = 0`
- Reset asserted mid-stream clears everything immediately (asynchronously), regardless of any pending stall or redirect.
- The first fetch after reset release uses `RESET_PC`. `o_if_valid` rises at the first non-stalled, non-redirected edge after release.
- Stage state: effectively two states, RUN and HOLD (HOLD while `i_stall=1` without a redirect). A redirect always returns the stage to RUN.

## Timing

- Instruction memory is combinational: `i_inst` is valid in the same cycle as `o_inst_addr`.
- Fetch latency: the address presented in cycle N appears on `o_if_inst` after edge N+1.
- Redirect sampled at edge E:
  - `o_inst_addr = target` after E.
  - The target instruction appears on `o_if_*` after E+1.
  - Exactly one bubble is produced by this stage.
- Stall sampled at edge E: outputs after E equal outputs before E.
- Back-to-back redirects: each is honoured, and the last one wins. IF/ID remains a bubble for every redirect cycle.
- `rst` deassertion is synchronised externally. This block needs no recovery cycle.

## Configuration

- Macro: `RV32I_IF_MISALIGN_CHK_EN`.
- Defined:
  - A redirect with `i_target[1:0] != 0` asserts `o_misalign` for exactly one cycle, registered at the redirect edge.
  - The redirect still proceeds, with the low bits cleared.
  - `o_misalign` is 0 in all other cycles.
- Undefined:
  - Low bits are cleared silently.
  - `o_misalign` is tied to 0 and no check logic is synthesised.

## Test plan

- **Reset and advance:** `RESET_PC=0`, memory preloaded; release `rst` with no stall or redirect.
  - Required: `o_inst_addr` = 0, 4, 8, … on successive cycles.
  - Required: `o_if_pc` trails by one cycle and `o_if_inst` = mem[pc>>2]; `o_if_valid` rises after the first edge.
- **Stall:** at `pc=0x10`, hold `i_stall=1` for 3 cycles.
  - Required: `o_inst_addr` stays 0x10 and IF/ID stays at pc 0x0C.
  - Required: after release, 0x10 then 0x14 appear with no skip or duplicate.
- **Redirect:** at `pc=0x20`, pulse `i_redirect=1` with `i_target=0x80`.
  - Required: next `o_inst_addr=0x80`; IF/ID shows `NOP_INST` with `valid=0` for one cycle, then pc 0x80 with valid=1.
- **Redirect during stall:** `i_stall=1` and `i_redirect=1` (target 0x40) together.
  - Required: redirect wins; `pc=0x40`, then a bubble.
- **Wrap and mid-run reset:**
  - Wrap: `RESET_PC=32'hFFFF_FFF8`. Required: addresses FFFF_FFF8, FFFF_FFFC, 0, 4.
  - Mid-run reset: assert `rst` mid-cycle. Required: outputs reach reset values before the next clock edge.
- **Misalign check (macro defined):** redirect to 0x102.
  - Required: `pc=0x100` and `o_misalign=1` for one cycle.
  - Macro undefined: `o_misalign` stays 0.
